// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with one shared ALU, an internal instruction memory loaded through the
// initialize port, and a req/ack data-memory port that tolerates wait states.
//
// Optional feature macro: PERF_COUNTERS_EN (cycle and retired-instruction
// counters). When undefined, perf_cycles and perf_instrs are constant 0.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   initialize                      high: write imem, hold core at FETCH/pc=0
//   instruction_initialize_data     imem write data
//   instruction_initialize_address  imem byte address
//   dmem_req/we/addr/wdata          data-memory request (held until ack)
//   dmem_rdata, dmem_ack            data-memory response
//   pc_out, halted                  current PC, core in HALT
//   perf_cycles, perf_instrs        performance counters
module cpu_multicycle #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned IMEM_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              initialize,
   input  logic [31:0]       instruction_initialize_data,
   input  logic [31:0]       instruction_initialize_address,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic [31:0]       pc_out,
   output logic              halted,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_instrs
);

   localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
   localparam int unsigned REG_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
   logic              req_q, req_d, we_q, we_d, halted_q, halted_d;
   logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;

   logic [31:0]       imem_q [IMEM_DEPTH];
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rs_val, rt_val, alu_res;

   logic [5:0]  op, funct;
   logic [4:0]  rs_idx, rt_idx, rd_idx;
   logic [31:0] sext32, lui32, br_target;

   assign op        = ir_q[31:26];
   assign funct     = ir_q[5:0];
   assign rs_idx    = ir_q[25:21];
   assign rt_idx    = ir_q[20:16];
   assign rd_idx    = ir_q[15:11];
   assign sext32    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign lui32     = {ir_q[15:0], 16'h0000};
   // Branch target is relative to the PC already advanced in FETCH.
   assign br_target = pc_q + {sext32[29:0], 2'b00};

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign pc_out     = pc_q;
   assign halted     = halted_q;

   logic unused_bits;
   assign unused_bits = ^{ir_q[10:6], sext32[31:30], lui32, instruction_initialize_address};

   // Instruction memory load port.
   always_ff @(posedge clk) begin
      if (initialize)
         imem_q[instruction_initialize_address[IMEM_AW+1:2]] <= instruction_initialize_data;
   end

   // Register read: reg 0 and out-of-range indices read as zero.
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs_idx != 5'd0 && 32'(rs_idx) < NUM_REGS) rs_val = regs_q[rs_idx[REG_AW-1:0]];
      if (rt_idx != 5'd0 && 32'(rt_idx) < NUM_REGS) rt_val = regs_q[rt_idx[REG_AW-1:0]];
   end

   // Register file write; reg 0 and out-of-range writes are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else if (rf_we && rf_waddr != 5'd0 && 32'(rf_waddr) < NUM_REGS) begin
         regs_q[rf_waddr[REG_AW-1:0]] <= rf_wdata;
      end
   end

   // Shared ALU: R-type by funct, everything else adds the immediate.
   always_comb begin
      alu_res = '0;
      if (op == OP_RTYPE) begin
         case (funct)
            F_ADD:   alu_res = a_q + b_q;
            F_SUB:   alu_res = a_q - b_q;
            F_AND:   alu_res = a_q & b_q;
            F_OR:    alu_res = a_q | b_q;
            F_SLT:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
            default: alu_res = '0;
         endcase
      end else begin
         alu_res = a_q + imm_q;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      halted_d = halted_q;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (initialize) begin
         state_d  = S_FETCH;
         pc_d     = '0;
         req_d    = 1'b0;
         we_d     = 1'b0;
         halted_d = 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               ir_d    = imem_q[pc_q[IMEM_AW+1:2]];
               pc_d    = pc_q + 32'd4;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               a_d   = rs_val;
               b_d   = rt_val;
               imm_d = sext32[DATA_W-1:0];
               if (op == OP_HALT) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               alu_d   = alu_res;
               state_d = S_FETCH;
               case (op)
                  OP_RTYPE, OP_ADDI, OP_LUI: state_d = S_WB;
                  OP_LW, OP_SW: begin
                     state_d = S_MEM;
                     req_d   = 1'b1;
                     we_d    = (op == OP_SW);
                     addr_d  = alu_res;
                     wdata_d = b_q;
                  end
                  OP_BEQ: if (a_q == b_q) pc_d = br_target;
                  OP_BNE: if (a_q != b_q) pc_d = br_target;
                  OP_J:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                  default: ;
               endcase
            end
            S_MEM: begin
               // Request stays asserted and stable until the ack cycle.
               if (dmem_ack) begin
                  req_d = 1'b0;
                  we_d  = 1'b0;
                  if (op == OP_LW) begin
                     mdr_d   = dmem_rdata;
                     state_d = S_WB;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
            S_WB: begin
               rf_we   = 1'b1;
               state_d = S_FETCH;
               case (op)
                  OP_RTYPE: begin rf_waddr = rd_idx; rf_wdata = alu_q; end
                  OP_LW:    begin rf_waddr = rt_idx; rf_wdata = mdr_q; end
                  OP_LUI:   begin rf_waddr = rt_idx; rf_wdata = lui32[DATA_W-1:0]; end
                  default:  begin rf_waddr = rt_idx; rf_wdata = alu_q; end
               endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
         endcase
      end
   end

   // Architectural and control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         alu_q    <= alu_d;
         mdr_q    <= mdr_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         halted_q <= halted_d;
      end
   end

`ifdef PERF_COUNTERS_EN
   logic [31:0] cyc_q, ins_q;
   logic        retire_c;

   // An instruction retires when its last state hands back to FETCH.
   always_comb begin
      retire_c = 1'b0;
      if (!initialize && state_d == S_FETCH &&
          (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
         retire_c = 1'b1;
   end

   // The cycle that enters HALT is not counted, nor any cycle spent in it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else if (initialize) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         if (state_d != S_HALT) cyc_q <= cyc_q + 32'd1;
         if (retire_c)          ins_q <= ins_q + 32'd1;
      end
   end

   assign perf_cycles = cyc_q;
   assign perf_instrs = ins_q;
`else
   assign perf_cycles = '0;
   assign perf_instrs = '0;
`endif

endmodule
